// File: rtl/pipefetchq.sv
// Instruction prefetch queue: issues sequential fetches, buffers in-order responses, and flushes on redirect.
// Optional same-cycle response bypass to the queue head when FETCHQ_BYPASS_EN is defined.
module pipefetchq #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] RSTPC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  output logic        ireq,
  output logic [31:0] iaddr,
  input  logic        igrant,
  input  logic        ivalid,
  input  logic [31:0] irdata,
  input  logic        redir,
  input  logic [31:0] rpc,
  output logic        qvalid,
  output logic [31:0] qpc,
  output logic [31:0] qins,
  input  logic        qpop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Several redirects can stack stale responses beyond DEPTH, so drp is kept wide.
  localparam int DW = 16;

  logic [31:0]   r_fpc;
  logic [31:0]   r_rspc;
  logic [CW-1:0] r_out;
  logic [DW-1:0] r_drp;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_mem_pc  [DEPTH];
  logic [31:0]   r_mem_ins [DEPTH];
  logic [31:0]   r_hold_pc;
  logic [31:0]   r_hold_ins;

  logic          w_room;
  logic          w_grant;
  logic          w_drop;
  logic          w_resp;
  logic          w_accept;
  logic          w_empty;
  logic          w_bypass;
  logic          w_bypass_pop;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_ins;

  assign w_room   = ({1'b0, r_cnt} + {1'b0, r_out}) < (CW+1)'(DEPTH);
  assign ireq     = !clrn && !redir && w_room;
  assign iaddr    = r_fpc;
  assign w_grant  = ireq && igrant;
  assign w_empty  = (r_cnt == '0);
  assign w_drop   = ivalid && (r_drp != '0);
  assign w_resp   = ivalid && ((r_drp != '0) || (r_out != '0));
  assign w_accept = !clrn && !redir && ivalid && (r_drp == '0) && (r_out != '0);

`ifdef FETCHQ_BYPASS_EN
  assign w_bypass   = w_accept && w_empty;
  assign w_head_pc  = w_empty ? r_rspc : r_mem_pc[r_rptr];
  assign w_head_ins = w_empty ? irdata : r_mem_ins[r_rptr];
`else
  assign w_bypass   = 1'b0;
  assign w_head_pc  = r_mem_pc[r_rptr];
  assign w_head_ins = r_mem_ins[r_rptr];
`endif

  // A bypassed response taken by the consumer in the same cycle never lands in storage.
  assign w_bypass_pop = w_bypass && qpop;
  assign w_push       = w_accept && !w_bypass_pop;
  assign w_pop        = qpop && !w_empty && !redir;

  assign qvalid = !clrn && (!w_empty || w_bypass);
  assign qpc    = qvalid ? w_head_pc  : r_hold_pc;
  assign qins   = qvalid ? w_head_ins : r_hold_ins;

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_fpc  <= RSTPC;
      r_rspc <= RSTPC;
      r_out  <= '0;
      r_drp  <= '0;
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (redir) begin
      r_fpc  <= rpc;
      r_rspc <= rpc;
      r_out  <= '0;
      r_drp  <= r_drp + DW'(r_out) - DW'(w_resp);
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_grant)  r_fpc  <= r_fpc + 32'd4;
      if (w_drop)   r_drp  <= r_drp - DW'(1);
      if (w_accept) r_rspc <= r_rspc + 32'd4;
      if (w_push)   r_wptr <= r_wptr + AW'(1);
      if (w_pop)    r_rptr <= r_rptr + AW'(1);
      r_out <= r_out + CW'(w_grant) - CW'(w_accept);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wptr]  <= r_rspc;
      r_mem_ins[r_wptr] <= irdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_hold_pc  <= '0;
      r_hold_ins <= '0;
    end else if (qvalid) begin
      r_hold_pc  <= w_head_pc;
      r_hold_ins <= w_head_ins;
    end
  end
endmodule

// File: tb/tb_pipefetchq.sv
// Scoreboard bench for pipefetchq: directed fetch/redirect scenarios with a latency-programmable memory model.
module tb_pipefetchq;
  logic        clk;
  logic        clrn;
  logic        ireq;
  logic [31:0] iaddr;
  logic        igrant;
  logic        ivalid;
  logic [31:0] irdata;
  logic        redir;
  logic [31:0] rpc;
  logic        qvalid;
  logic [31:0] qpc;
  logic [31:0] qins;
  logic        qpop;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          lat      = 1;
  logic [31:0] mem_addr [$];
  int          mem_due  [$];
  logic [31:0] exp_pc   [$];
  logic [31:0] exp_ins  [$];

  pipefetchq #(.DEPTH(4), .RSTPC(32'h0000_0000)) dut (
    .clk(clk), .clrn(clrn), .ireq(ireq), .iaddr(iaddr), .igrant(igrant),
    .ivalid(ivalid), .irdata(irdata), .redir(redir), .rpc(rpc),
    .qvalid(qvalid), .qpc(qpc), .qins(qins), .qpop(qpop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    if (a == 32'h0000_0300) return 32'h2002_0005;
    return 32'hA000_0000 | a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc);
    exp_pc.push_back(pc);
    exp_ins.push_back(memdata(pc));
  endtask

  // Present this cycle's memory response, then let inputs settle.
  task automatic drive();
    ivalid = 1'b0;
    irdata = 32'h0;
    if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
      ivalid = 1'b1;
      irdata = memdata(mem_addr[0]);
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    #1;
  endtask

  task automatic tick();
    if (clrn) begin
      mem_addr.delete();
      mem_due.delete();
    end else if (ireq && igrant) begin
      mem_addr.push_back(iaddr);
      mem_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    igrant = 1'b0;
    qpop   = 1'b1;
    while (exp_pc.size() > 0 && n < budget) begin
      drive();
      tick();
      n++;
    end
    chk(name, 32'(exp_pc.size()), 32'd0);
    qpop = 1'b0;
  endtask

  // Monitor: every head the consumer takes must match the oldest expected entry.
  always @(negedge clk) begin
    if (!clrn && qvalid && qpop && !redir) begin
      if (exp_pc.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL pop_unexpected: got pc=%h ins=%h expected none", qpc, qins);
      end else begin
        $display("pop pc=%h ins=%h (expected pc=%h ins=%h)", qpc, qins, exp_pc[0], exp_ins[0]);
        chk("pop_pc", qpc, exp_pc[0]);
        chk("pop_ins", qins, exp_ins[0]);
        void'(exp_pc.pop_front());
        void'(exp_ins.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clrn = 1'b1; igrant = 1'b1; qpop = 1'b0; redir = 1'b0; rpc = 32'h0;
    ivalid = 1'b0; irdata = 32'h0;
    @(posedge clk);
    #1;
    drive();
    chk("rst_ireq", 32'(ireq), 32'd0);
    chk("rst_qvalid", 32'(qvalid), 32'd0);
    tick();
    drive();
    tick();
    clrn = 1'b0;

    // Fill: four grants at 0,4,8,12 with 1-cycle memory, no consumer.
    lat = 1;
    for (int k = 0; k < 4; k++) expect_entry(32'(4 * k));
    for (int k = 0; k < 4; k++) begin
      drive();
      chk("fill_ireq", 32'(ireq), 32'd1);
      chk("fill_iaddr", iaddr, 32'(4 * k));
      tick();
    end
    drive();
    chk("full_ireq_low", 32'(ireq), 32'd0);
    tick();
    qpop = 1'b1;
    drive();
    chk("full_qvalid", 32'(qvalid), 32'd1);
    chk("full_head_pc", qpc, 32'h0);
    chk("full_ireq_still_low", 32'(ireq), 32'd0);
    tick();

    // One pop frees a slot: head advances to 4 and fetch resumes at 16.
    qpop = 1'b0;
    drive();
    chk("pop1_qpc", qpc, 32'd4);
    chk("pop1_ireq", 32'(ireq), 32'd1);
    chk("pop1_iaddr", iaddr, 32'd16);
    expect_entry(32'd16);
    tick();
    drive();
    tick();

    // Memory refuses grants for 5 cycles while the queue drains.
    igrant = 1'b0;
    qpop   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive();
      chk("stall_iaddr", iaddr, 32'd20);
      tick();
    end
    drive();
    chk("stall_qvalid_low", 32'(qvalid), 32'd0);
    chk("stall_ireq_idle", 32'(ireq), 32'd1);
    chk("stall_sb_empty", 32'(exp_pc.size()), 32'd0);
    tick();
    qpop = 1'b0;

    // Redirect with two requests in flight (3-cycle latency).
    lat = 3;
    igrant = 1'b1;
    drive();
    chk("rd2_iaddr0", iaddr, 32'd20);
    tick();
    drive();
    tick();
    redir = 1'b1; rpc = 32'h100;
    drive();
    chk("rd2_ireq_during", 32'(ireq), 32'd0);
    tick();
    redir = 1'b0;
    expect_entry(32'h100);
    expect_entry(32'h104);
    drive();
    chk("rd2_iaddr_tgt", iaddr, 32'h100);
    chk("rd2_qvalid_low", 32'(qvalid), 32'd0);
    tick();
    drive();
    tick();
    drain("rd2_drain", 12);

    // Redirect coinciding with a response (2-cycle latency).
    lat = 2;
    igrant = 1'b1;
    drive();
    chk("rdc_iaddr0", iaddr, 32'h108);
    tick();
    drive();
    tick();
    redir = 1'b1; rpc = 32'h200;
    drive();
    tick();
    redir = 1'b0;
    expect_entry(32'h200);
    drive();
    chk("rdc_iaddr_tgt", iaddr, 32'h200);
    tick();
    drain("rdc_drain", 10);

    // Response into an empty queue with the consumer popping.
    igrant = 1'b0;
    redir = 1'b1; rpc = 32'h300;
    drive();
    tick();
    redir = 1'b0;
    igrant = 1'b1;
    lat = 1;
    drive();
    chk("byp_iaddr", iaddr, 32'h300);
    tick();
    igrant = 1'b0;
    qpop = 1'b1;
    expect_entry(32'h300);
    drive();
`ifdef FETCHQ_BYPASS_EN
    chk("byp_same_qvalid", 32'(qvalid), 32'd1);
    chk("byp_same_qins", qins, 32'h2002_0005);
    chk("byp_same_qpc", qpc, 32'h300);
`else
    chk("byp_same_qvalid", 32'(qvalid), 32'd0);
`endif
    tick();
    drive();
`ifdef FETCHQ_BYPASS_EN
    chk("byp_next_qvalid", 32'(qvalid), 32'd0);
`else
    chk("byp_next_qvalid", 32'(qvalid), 32'd1);
    chk("byp_next_qins", qins, 32'h2002_0005);
`endif
    tick();
    drive();
    chk("byp_after_qvalid", 32'(qvalid), 32'd0);
    chk("byp_sb_empty", 32'(exp_pc.size()), 32'd0);
    tick();
    qpop = 1'b0;

    // Reset mid-flight abandons outstanding requests.
    lat = 2;
    igrant = 1'b1;
    drive();
    tick();
    drive();
    tick();
    clrn = 1'b1;
    drive();
    chk("mrst_ireq", 32'(ireq), 32'd0);
    tick();
    clrn = 1'b0;
    igrant = 1'b0;
    drive();
    chk("mrst_iaddr", iaddr, 32'h0);
    chk("mrst_qvalid", 32'(qvalid), 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive();
      tick();
    end
    drive();
    chk("mrst_qvalid_late", 32'(qvalid), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/pipefetchq.md
PIPEFETCHQ -- requirements
Module: pipefetchq

Interface
REQ-001 Parameter DEPTH, default 4, queue entries and maximum outstanding requests; power of 2, minimum 2.
REQ-002 Parameter RSTPC, default 32'h0000_0000, fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 clrn  input  1  reset; synchronous, active-high (1 = reset).
REQ-005 ireq  output  1  instruction-memory request valid.
REQ-006 iaddr  output  32  instruction-memory request word address (byte address, [1:0]=0).
REQ-007 igrant  input  1  memory accepts request this cycle; ignored when ireq=0.
REQ-008 ivalid  input  1  read response valid; responses return in request order, at least 1 cycle after grant.
REQ-009 irdata  input  32  read response data.
REQ-010 redir  input  1  ID-stage redirect (branch/jump taken).
REQ-011 rpc  input  32  redirect target address.
REQ-012 qvalid  output  1  queue head holds a valid instruction.
REQ-013 qpc  output  32  byte address of head instruction.
REQ-014 qins  output  32  head instruction word.
REQ-015 qpop  input  1  consumer takes head; ignored when qvalid=0.

Function
REQ-016 Fetch counter fpc drives iaddr; on a grant (ireq&igrant) fpc advances by 4 (mod 2^32).
REQ-017 Outstanding counter out = granted requests whose response is not yet received; ireq=1 only when occupancy+out < DEPTH and redir=0.
REQ-018 Drop counter drp: when redir=1, drp <= drp+out minus any response arriving that cycle; out <= 0; fpc <= rpc; queue flushed (occupancy 0); response PC rspc <= rpc.
REQ-019 A response with ivalid=1 while drp>0 is discarded and decrements drp; it never enters the queue.
REQ-020 A response with drp=0 and out>0 is written to the queue tail with PC rspc; rspc advances by 4; out decrements.
REQ-021 ivalid with out=0 and drp=0 is ignored (no state change).
REQ-022 Push and pop in the same cycle are both performed; occupancy unchanged.
REQ-023 Grant and response in the same cycle: out unchanged.
REQ-024 A written entry appears on qvalid/qpc/qins the cycle after the write (unless REQ-030 applies).
REQ-025 qvalid=0 when occupancy=0; qpc/qins then hold the last driven value and carry no meaning.
REQ-026 redir has priority over qpop and over push in the same cycle; a queue-head pop coincident with redir is not reported to the consumer.
REQ-027 Read/write pointers wrap modulo DEPTH; occupancy never exceeds DEPTH (guaranteed by REQ-017).

Reset
REQ-028 With clrn=1 at a rising edge: fpc=RSTPC, rspc=RSTPC, out=0, drp=0, occupancy=0, pointers=0; during the reset cycle ireq=0 and qvalid=0.
REQ-029 Reset mid-operation abandons outstanding requests without drop accounting. Responses arriving after reset release are ignored per REQ-021. The memory side is reset on the same clrn.

Configuration
REQ-030 Macro FETCHQ_BYPASS_EN. If defined, an accepted response with occupancy=0 drives qvalid=1, qpc=rspc, qins=irdata combinationally in the same cycle. If qpop=1 that cycle, it is not written to the queue. Otherwise it is written as usual. If undefined, REQ-024 holds with no bypass path.

Verification
REQ-031 Reset, igrant=1 constant, 1-cycle memory latency, qpop=0 -> iaddr 0,4,8,12 granted; ireq drops after 4 grants; queue holds PCs 0..12; qvalid=1.
REQ-032 Full queue, then qpop=1 for one cycle -> qpc advances 0->4; ireq reasserts next cycle with iaddr=16.
REQ-033 2 outstanding requests, redir=1 with rpc=32'h100 -> next cycle iaddr=32'h100, qvalid=0; the 2 stale responses are discarded; first queued qpc=32'h100.
REQ-034 Redirect in same cycle as a response -> that response is discarded and drp counts only the remainder; no stale PC ever reaches qpc.
REQ-035 igrant=0 for 5 cycles -> iaddr held, out=0, qvalid falls after the queue drains.
REQ-036 FETCHQ_BYPASS_EN defined, empty queue, response 32'h2002_0005 with qpop=1 -> qins=32'h2002_0005 same cycle; occupancy stays 0; undefined -> appears next cycle.
